// File: rtl/obuffer4_deskew.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | obuffer4_deskew: re-aligns 4 skewed MAC-array lanes into packed words.     |
// | Optional skew checker built when OBUF_SKEW_CHECK_EN is defined.           |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module obuffer4_deskew #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int NUM_ROWS = 4
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                CLEAR,
  input  logic [4*DATA_W-1:0] OROW_i,
  input  logic [3:0]          OCOL_VALID,
  input  logic [3:0]          ODST_i,
  output logic [4*DATA_W-1:0] OWORD_o,
  output logic                OWORD_VALID,
  input  logic                OWORD_READY,
  output logic [3:0]          ODST_o,
  output logic [2:0]          ROW_CNT,
  output logic                TILE_DONE,
  output logic                OVF,
  output logic                SKEW_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [4*DATA_W-1:0] r_word;
  logic                r_valid;
  logic [3:0]          r_dst;
  logic [2:0]          r_row_cnt;
  logic                r_tile_done;
  logic                r_ovf;

  logic [3:0]          w_empty;
  logic [3:0]          w_full;
  logic [3:0]          w_push_ok;
  logic [3:0]          w_push_ovf;
  logic [4*DATA_W-1:0] w_heads;
  logic                w_pop;
  logic                w_accept;

  assign w_pop    = (~|w_empty) && (!r_valid || OWORD_READY);
  assign w_accept = r_valid && OWORD_READY;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_lane
      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [PW-1:0]     r_wp;
      logic [PW-1:0]     r_rp;

      assign w_empty[k] = (r_wp == r_rp);
      assign w_full[k]  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
      // A pop in the same cycle frees the slot, so a push to a full lane still lands.
      assign w_push_ok[k]  = OCOL_VALID[k] && (!w_full[k] || w_pop);
      assign w_push_ovf[k] = OCOL_VALID[k] && w_full[k] && !w_pop;
      assign w_heads[(4-k)*DATA_W-1 -: DATA_W] = r_mem[r_rp[AW-1:0]];

      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          r_wp <= '0;
          r_rp <= '0;
        end else if (CLEAR) begin
          r_wp <= '0;
          r_rp <= '0;
        end else begin
          if (w_push_ok[k]) r_wp <= r_wp + PW'(1);
          if (w_pop)        r_rp <= r_rp + PW'(1);
        end
      end

      always_ff @(posedge CLK) begin
        if (w_push_ok[k] && !CLEAR) r_mem[r_wp[AW-1:0]] <= OROW_i[(4-k)*DATA_W-1 -: DATA_W];
      end
    end
  endgenerate

  // Tag FIFO tracks lane 0 exactly: same push and pop conditions.
  logic [3:0]    r_tag_mem [DEPTH];
  logic [PW-1:0] r_tag_wp;
  logic [PW-1:0] r_tag_rp;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_tag_wp <= '0;
      r_tag_rp <= '0;
    end else if (CLEAR) begin
      r_tag_wp <= '0;
      r_tag_rp <= '0;
    end else begin
      if (w_push_ok[0]) r_tag_wp <= r_tag_wp + PW'(1);
      if (w_pop)        r_tag_rp <= r_tag_rp + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push_ok[0] && !CLEAR) r_tag_mem[r_tag_wp[AW-1:0]] <= ODST_i;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_valid     <= 1'b0;
      r_dst       <= '0;
      r_row_cnt   <= '0;
      r_tile_done <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (CLEAR) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_valid     <= 1'b0;
      r_dst       <= '0;
      r_row_cnt   <= '0;
      r_tile_done <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_pop) begin
        r_word  <= w_heads;
        r_dst   <= r_tag_mem[r_tag_rp[AW-1:0]];
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (|w_push_ovf) r_ovf <= 1'b1;
      r_tile_done <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN: begin
          if (r_state == S_IDLE && |OCOL_VALID) r_state <= S_RUN;
          if (w_accept) begin
            r_row_cnt <= r_row_cnt + 3'd1;
            if (r_row_cnt == LAST_ROW) begin
              r_state     <= S_DONE;
              r_tile_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          // A next-tile word accepted right here is counted toward the new tile.
          r_row_cnt <= w_accept ? 3'd1 : 3'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign OWORD_o     = r_word;
  assign OWORD_VALID = r_valid;
  assign ODST_o      = r_dst;
  assign ROW_CNT     = r_row_cnt;
  assign TILE_DONE   = r_tile_done;
  assign OVF         = r_ovf;

`ifdef OBUF_SKEW_CHECK_EN
  logic [2:0] r_vdly;
  logic       r_skew_err;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_vdly     <= '0;
      r_skew_err <= 1'b0;
    end else if (CLEAR) begin
      r_vdly     <= '0;
      r_skew_err <= 1'b0;
    end else begin
      r_vdly <= OCOL_VALID[2:0];
      if (OCOL_VALID[3:1] != r_vdly) r_skew_err <= 1'b1;
    end
  end

  assign SKEW_ERR = r_skew_err;
`else
  assign SKEW_ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_obuffer4_deskew.sv
`default_nettype none
// Bench for obuffer4_deskew: table-driven skewed streams with a word scoreboard,
// plus hand-written overflow, full push/pop, clear/reset and skew sequences.
module tb_obuffer4_deskew;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        CLEAR = 1'b0;
  logic [31:0] OROW_i = '0;
  logic [3:0]  OCOL_VALID = '0;
  logic [3:0]  ODST_i = '0;
  logic [31:0] OWORD_o;
  logic        OWORD_VALID;
  logic        OWORD_READY = 1'b1;
  logic [3:0]  ODST_o;
  logic [2:0]  ROW_CNT;
  logic        TILE_DONE;
  logic        OVF;
  logic        SKEW_ERR;

  obuffer4_deskew #(.DATA_W(8), .DEPTH(4), .NUM_ROWS(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .CLEAR(CLEAR), .OROW_i(OROW_i), .OCOL_VALID(OCOL_VALID),
    .ODST_i(ODST_i), .OWORD_o(OWORD_o), .OWORD_VALID(OWORD_VALID),
    .OWORD_READY(OWORD_READY), .ODST_o(ODST_o), .ROW_CNT(ROW_CNT),
    .TILE_DONE(TILE_DONE), .OVF(OVF), .SKEW_ERR(SKEW_ERR)
  );

  always #5 CLK = ~CLK;

`ifdef OBUF_SKEW_CHECK_EN
  localparam logic EXP_SKEW = 1'b1;
`else
  localparam logic EXP_SKEW = 1'b0;
`endif

  typedef struct {
    logic [31:0] row;
    logic [3:0]  tag;
    logic [31:0] exp_word;
    logic [3:0]  exp_tag;
  } vec_t;

  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  t;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   tile_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input logic [3:0] t);
    exp_t e;
    e.w = w;
    e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    OCOL_VALID = '0;
    OROW_i = '0;
    ODST_i = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_clear();
    OCOL_VALID = '0;
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard: compare every accepted word against the head of the queue.
  always @(negedge CLK) begin
    if (RSTN && !CLEAR && OWORD_VALID && OWORD_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none", OWORD_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word", OWORD_o, e.w);
        check("tag", {28'd0, ODST_o}, {28'd0, e.t});
      end
    end
    if (RSTN && TILE_DONE) begin
      tile_pulses++;
      check("row_cnt_at_done", {29'd0, ROW_CNT}, 32'd4);
    end
  end

  // Drive n rows from vecs[base..] with lane k delayed k cycles. READY is low for
  // cycles in [hold_lo, hold_hi). stop_at >= 0 aborts the stream at that cycle.
  task automatic run_stream(input int base, input int n, input int hold_lo, input int hold_hi,
                            input int stop_at, input bit chk_lat);
    logic [3:0]  v;
    logic [31:0] d;
    logic [31:0] src;
    logic [3:0]  t;
    int          last;
    int          r;
    last = n + 6 + ((hold_hi > 0) ? hold_hi : 0);
    for (int c = 0; c <= last && c != stop_at; c++) begin
      v = '0;
      d = '0;
      t = '0;
      for (int k = 0; k < 4; k++) begin
        r = c - k;
        if (r >= 0 && r < n) begin
          v[k] = 1'b1;
          src = vecs[base + r].row;
          d[(4-k)*8-1 -: 8] = src[(4-k)*8-1 -: 8];
        end
      end
      if (c < n) begin
        t = vecs[base + c].tag;
        push_exp(vecs[base + c].exp_word, vecs[base + c].exp_tag);
      end
      OCOL_VALID = v;
      OROW_i = d;
      ODST_i = t;
      OWORD_READY = !(c >= hold_lo && c < hold_hi);
      tick();
      if (chk_lat && c == 3) check("latency_not_yet", {31'd0, OWORD_VALID}, 32'd0);
      if (chk_lat && c == 4) check("latency_valid", {31'd0, OWORD_VALID}, 32'd1);
      if (c >= hold_lo && c < hold_hi) begin
        check("hold_valid", {31'd0, OWORD_VALID}, 32'd1);
        check("hold_word", OWORD_o, vecs[base].exp_word);
      end
    end
    OCOL_VALID = '0;
    OROW_i = '0;
    ODST_i = '0;
    OWORD_READY = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h11223344, 4'd1,  32'h11223344, 4'd1};
    vecs[1] = '{32'h55667788, 4'd2,  32'h55667788, 4'd2};
    vecs[2] = '{32'h99AABBCC, 4'd3,  32'h99AABBCC, 4'd3};
    vecs[3] = '{32'hDDEEFF00, 4'd4,  32'hDDEEFF00, 4'd4};
    vecs[4] = '{32'hCAFEF00D, 4'd7,  32'hCAFEF00D, 4'd7};
    vecs[5] = '{32'h0F1E2D3C, 4'd9,  32'h0F1E2D3C, 4'd9};
    vecs[6] = '{32'hFFFFFFFF, 4'd15, 32'hFFFFFFFF, 4'd15};
    vecs[7] = '{32'h00000001, 4'd0,  32'h00000001, 4'd0};

    repeat (3) @(posedge CLK);
    #1;
    check("reset_word", OWORD_o, 32'd0);
    check("reset_flags", {21'd0, OWORD_VALID, ODST_o, ROW_CNT, TILE_DONE, OVF, SKEW_ERR}, 32'd0);
    RSTN = 1'b1;
    tick();

    // Nominal tile
    tile_pulses = 0;
    run_stream(0, 4, 100, 0, -1, 1'b1);
    check("nominal_tile_pulses", tile_pulses, 32'd1);
    check("nominal_ovf", {31'd0, OVF}, 32'd0);
    check("nominal_drained", exp_q.size(), 32'd0);
    check("nominal_row_cnt_idle", {29'd0, ROW_CNT}, 32'd0);

    // Backpressure for 6 cycles
    tile_pulses = 0;
    run_stream(0, 4, 4, 10, -1, 1'b0);
    check("bp_tile_pulses", tile_pulses, 32'd1);
    check("bp_drained", exp_q.size(), 32'd0);
    check("bp_ovf", {31'd0, OVF}, 32'd0);

    // Second tile with other data patterns
    tile_pulses = 0;
    run_stream(4, 4, 100, 0, -1, 1'b0);
    check("tile2_pulses", tile_pulses, 32'd1);
    check("tile2_drained", exp_q.size(), 32'd0);

    // CLEAR mid-tile with two rows partially buffered
    run_stream(0, 2, 100, 0, -1, 1'b0);
    check("pre_clear_row_cnt", {29'd0, ROW_CNT}, 32'd2);
    run_stream(0, 4, 100, 0, 2, 1'b0);
    pulse_clear();
    check("clear_flags", {27'd0, OWORD_VALID, ROW_CNT, OVF}, 32'd0);
    run_stream(4, 1, 100, 0, -1, 1'b0);
    check("clear_next_row_cnt", {29'd0, ROW_CNT}, 32'd1);
    check("clear_drained", exp_q.size(), 32'd0);

    // Asynchronous reset mid-tile
    run_stream(0, 2, 100, 0, -1, 1'b0);
    run_stream(0, 4, 100, 0, 2, 1'b0);
    RSTN = 1'b0;
    #1;
    check("rstn_async_flags", {27'd0, OWORD_VALID, ROW_CNT, OVF}, 32'd0);
    tick();
    RSTN = 1'b1;
    exp_q.delete();
    tick();
    run_stream(5, 1, 100, 0, -1, 1'b0);
    check("rstn_next_row_cnt", {29'd0, ROW_CNT}, 32'd1);
    check("rstn_drained", exp_q.size(), 32'd0);

    // Overflow on lane 0 while the output is blocked
    pulse_clear();
    OWORD_READY = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      OCOL_VALID = 4'b0001;
      OROW_i = {8'hA0 + 8'(i), 24'd0};
      ODST_i = 4'(i);
      tick();
      if (i == 4) check("ovf_before_5th", {31'd0, OVF}, 32'd0);
      if (i == 5) check("ovf_after_5th", {31'd0, OVF}, 32'd1);
    end
    OWORD_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      OCOL_VALID = 4'b1110;
      OROW_i = {8'h00, 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i)};
      push_exp({8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i)}, 4'(i));
      tick();
    end
    idle(8);
    check("ovf_drained", exp_q.size(), 32'd0);
    check("ovf_sticky", {31'd0, OVF}, 32'd1);
    pulse_clear();
    check("ovf_cleared", {31'd0, OVF}, 32'd0);

    // Push into full lanes while a pop frees a slot
    OWORD_READY = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      OCOL_VALID = 4'b1111;
      OROW_i = 32'h10203040 + 32'h01010101 * 32'(i);
      ODST_i = 4'(i);
      push_exp(32'h10203040 + 32'h01010101 * 32'(i), 4'(i));
      tick();
    end
    check("full_ovf_before", {31'd0, OVF}, 32'd0);
    OWORD_READY = 1'b1;
    OCOL_VALID = 4'b0001;
    OROW_i = {8'h5A, 24'd0};
    ODST_i = 4'd6;
    tick();
    check("full_pushpop_ovf", {31'd0, OVF}, 32'd0);
    OCOL_VALID = 4'b1110;
    OROW_i = {8'h00, 8'h6B, 8'h7C, 8'h8D};
    push_exp(32'h5A6B7C8D, 4'd6);
    tick();
    idle(10);
    check("full_drained", exp_q.size(), 32'd0);
    check("full_ovf_after", {31'd0, OVF}, 32'd0);

    // Lanes 1 and 2 pushed in the same cycle
    pulse_clear();
    check("skew_clear", {31'd0, SKEW_ERR}, 32'd0);
    OCOL_VALID = 4'b0110;
    OROW_i = 32'h00BBCC00;
    tick();
    OCOL_VALID = '0;
    check("skew_set", {31'd0, SKEW_ERR}, {31'd0, EXP_SKEW});
    idle(3);
    check("skew_sticky", {31'd0, SKEW_ERR}, {31'd0, EXP_SKEW});
    pulse_clear();
    check("skew_cleared", {31'd0, SKEW_ERR}, 32'd0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obuffer4_deskew.md
Name: obuffer4_deskew

Overview:
- Output-side counterpart to the 4-column input skew buffer of the MAC array.
- Collects 4 lanes of results leaving the array. Lane k arrives k cycles after lane 0.
- De-skews the lanes through per-lane FIFOs and re-packs each row into one 32-bit word for write-back.
- Emits each word with a valid/ready handshake and a registered destination tag.

Parameters:
- DATA_W, 8: bits per lane; word width is 4*DATA_W.
- DEPTH, 4: entries per lane FIFO; power of 2, minimum 2.
- NUM_ROWS, 4: rows per tile; completing this many emitted words ends the tile.

Ports:
- CLK  input  1  clock
- RSTN  input  1  asynchronous active-low reset
- CLEAR  input  1  synchronous clear; empties FIFOs, resets counters and flags, returns to IDLE
- OROW_i  input  4*DATA_W  lane data; lane 0 = bits [4*DATA_W-1 -: DATA_W], lane 3 = LSBs
- OCOL_VALID  input  4  per-lane push strobes, skewed by one cycle per lane
- ODST_i  input  4  destination tag; sampled with OCOL_VALID[0]
- OWORD_o  output  4*DATA_W  packed row {lane0,lane1,lane2,lane3}
- OWORD_VALID  output  1  OWORD_o and ODST_o hold a valid word
- OWORD_READY  input  1  consumer accepts the word when asserted with OWORD_VALID
- ODST_o  output  4  tag of the word currently on OWORD_o
- ROW_CNT  output  3  words accepted in the current tile (0..NUM_ROWS)
- TILE_DONE  output  1  one-cycle pulse when the NUM_ROWS-th word is accepted
- OVF  output  1  sticky; a push hit a full lane FIFO
- SKEW_ERR  output  1  sticky skew violation (see Optional Feature)

Behaviour:
- Reset (RSTN low) or CLEAR: all FIFOs empty, state IDLE, and every output is 0 (OWORD_o, OWORD_VALID, ODST_o, ROW_CNT, TILE_DONE, OVF, SKEW_ERR). CLEAR overrides pushes and pops in the same cycle.
- Lane FIFO k (0..3): a push on OCOL_VALID[k] writes the DATA_W slice of lane k. The tag FIFO is pushed in lockstep with lane 0. Pointers are log2(DEPTH)+1 bits wide with wrap bit; full = pointers equal except the MSB.
- Push to a full lane: data is dropped, OVF is set, and the other lanes are unaffected.
- Pop condition, "row ready": all four lane FIFOs are non-empty and (!OWORD_VALID || OWORD_READY).
  - All four lane FIFOs and the tag FIFO pop together.
  - The output register loads on the next edge, so latency from the lane-3 push to OWORD_VALID is 1 cycle when the output is free.
- Push and pop of the same lane in the same cycle are both performed; occupancy is unchanged. A push to a full lane that is also popped that cycle succeeds, with no OVF.
- Handshake:
  - OWORD_VALID stays high and OWORD_o/ODST_o stay stable until OWORD_READY is sampled high.
  - Back-to-back words need no gap cycle, since pop and accept happen in the same cycle.
- FSM:
  - IDLE -> RUN on any OCOL_VALID bit.
  - RUN -> DONE when a word is accepted with ROW_CNT == NUM_ROWS-1. In that cycle ROW_CNT becomes NUM_ROWS and TILE_DONE pulses.
  - DONE -> IDLE next cycle; ROW_CNT returns to 0 on that transition.
- Pushes in DONE/IDLE are still accepted, so a following tile may start immediately.
- With the array's nominal skew, at most 3 rows are partially buffered. DEPTH=4 therefore never overflows while OWORD_READY stays high.

Optional Feature:
- Macro: OBUF_SKEW_CHECK_EN.
- Defined: for k=1..3, a push on lane k is checked against a 1-cycle delayed copy of OCOL_VALID[k-1].
  - Violation: OCOL_VALID[k] high while the delayed OCOL_VALID[k-1] is low, or the reverse.
  - On violation SKEW_ERR sets, sticky, and clears only on reset/CLEAR.
  - Datapath behaviour is unchanged.
- Not defined: SKEW_ERR is tied to 0 and no checker logic is built.

Test Plan:
- Nominal skew, OWORD_READY=1:
  - Stimulus: rows 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00 with tags 1,2,3,4, lane k delayed k cycles.
  - Response: 4 words in order with matching ODST_o; first OWORD_VALID 1 cycle after the first lane-3 push; TILE_DONE pulses once when ROW_CNT reaches 4; OVF=0.
- Backpressure:
  - Stimulus: OWORD_READY=0 for 6 cycles during the above stream.
  - Response: OWORD_o holds 0x11223344 stable; on release, all 4 words arrive in order without loss.
- Overflow:
  - Stimulus: OWORD_READY=0 and 5 pushes on lane 0 with DEPTH=4.
  - Response: OVF=1 after the 5th push; after drain, the first emitted word carries lane-0 byte from push 1, not push 5.
- Reset/CLEAR mid-operation:
  - Stimulus: CLEAR or RSTN low after 2 rows are partially pushed.
  - Response: OWORD_VALID=0, ROW_CNT=0, OVF=0; the next full row emits correctly as the first word.
- Simultaneous push/pop at full:
  - Stimulus: lane FIFOs hold 4 entries and OWORD_READY=1 while lane 0 pushes.
  - Response: push accepted, OVF stays 0.
- With OBUF_SKEW_CHECK_EN:
  - Stimulus: lane 2 pushed in the same cycle as lane 1.
  - Response: SKEW_ERR=1 the next cycle and stays set until CLEAR.
